q2_sequencer: RTL and testbench

- Clocked state sequencer for the Q2 control decoder: generates state bits s0..s3 and the write strobe ws that the decoder turns into register and memory enables.
- Walks FETCH -> [DEREF] -> [LOAD] -> EXEC -> [ALU shift] -> FETCH.
- Adds front-panel run/halt/deposit control.
- Sits between the front panel and the control decoder; clocks the whole CPU.

---
 rtl/q2_seq_pkg.sv | 16 +
 rtl/q2_sequencer_edge_det.sv | 18 +
 rtl/q2_sequencer.sv | 109 ++++++++++
 tb/tb_q2_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/q2_seq_pkg.sv
// q2_seq_pkg: shared state encoding, phase codes and opcode decode for the Q2 sequencer.
package q2_seq_pkg;

    typedef enum logic [2:0] {FETCH, DEREF, LOAD, EXEC, ALU, HALT} state_t;

    // Phase codes as seen by the decoder on {s1, s0}
    localparam logic [1:0] PH_FETCH = 2'b00;
    localparam logic [1:0] PH_DEREF = 2'b01;
    localparam logic [1:0] PH_LOAD  = 2'b10;
    localparam logic [1:0] PH_EXEC  = 2'b11;

    function automatic logic alu_op(input logic o0, input logic o1, input logic o2);
        return (o0 | o1) & o2;
    endfunction

endpackage

// File: rtl/q2_sequencer_edge_det.sv
// q2_edge_det: registers a level input and flags its rising edge in the same cycle.
module q2_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prev <= 1'b0;
        else     prev <= d;
    end

    assign rise = d & ~prev;

endmodule

// File: rtl/q2_sequencer.sv
// q2_sequencer: two-clock-per-state CPU sequencer with ALU shift steps and front-panel run/halt/deposit.
// Optional single-step control (step_sw) is built when Q2_SINGLE_STEP_EN is defined.
module q2_sequencer
    import q2_seq_pkg::*;
#(
    parameter int SHIFT_CYCLES = 12,
    parameter int CNT_W        = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef Q2_SINGLE_STEP_EN
    input  logic step_sw,
`endif
    input  logic run_sw,
    input  logic dep_sw,
    input  logic deref,
    input  logic o0,
    input  logic o1,
    input  logic o2,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic s3,
    output logic ws,
    output logic halted,
    output logic dep_ws
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SHIFT_CYCLES - 1);

    state_t           state, state_n;
    logic             strobe, strobe_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             dep_n, dep_rise, go, park, step_go;

    q2_edge_det u_dep (.clk(clk), .rst(rst), .d(dep_sw), .rise(dep_rise));

`ifdef Q2_SINGLE_STEP_EN
    logic step_rise, stepping;

    q2_edge_det u_step (.clk(clk), .rst(rst), .d(step_sw), .rise(step_rise));

    // Latched on leaving HALT; forces a return to HALT after this one instruction
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                stepping <= 1'b0;
        else if (state == HALT) stepping <= step_rise;
    end

    assign step_go = step_rise;
    assign park    = ~run_sw | stepping;
`else
    assign step_go = 1'b0;
    assign park    = ~run_sw;
`endif

    assign go = run_sw | step_go;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= HALT;
            strobe <= 1'b0;
            cnt    <= '0;
            dep_ws <= 1'b0;
        end else begin
            state  <= state_n;
            strobe <= strobe_n;
            cnt    <= cnt_n;
            dep_ws <= dep_n;
        end
    end

    always_comb begin
        state_n  = state;
        strobe_n = 1'b0;
        cnt_n    = cnt;
        dep_n    = 1'b0;
        if (state == HALT) begin
            state_n = go ? FETCH : HALT;
            dep_n   = dep_rise & ~go;
        end else begin
            strobe_n = ~strobe;
            if (strobe) begin
                case (state)
                    FETCH:   state_n = deref ? DEREF : (o2 ? EXEC : LOAD);
                    DEREF:   state_n = o2 ? EXEC : LOAD;
                    LOAD:    state_n = EXEC;
                    EXEC: begin
                        state_n = alu_op(o0, o1, o2) ? ALU : (park ? HALT : FETCH);
                        cnt_n   = '0;
                    end
                    default: begin
                        state_n = (cnt == LAST) ? (park ? HALT : FETCH) : ALU;
                        cnt_n   = cnt + 1'b1;
                    end
                endcase
            end
        end
    end

    // ALU steps keep the EXEC phase code so the decoder sees EXEC plus the shift bits
    assign {s1, s0} = (state == DEREF) ? PH_DEREF :
                      (state == LOAD)  ? PH_LOAD  :
                      (state == EXEC || state == ALU) ? PH_EXEC : PH_FETCH;
    assign s2     = (state == ALU) && (cnt < LAST);
    assign s3     = (state == ALU) && (cnt == LAST);
    assign ws     = strobe;
    assign halted = (state == HALT);

endmodule

// File: tb/tb_q2_sequencer.sv
// tb_q2_sequencer: randomized self-checking bench for q2_sequencer against a per-instruction phase-list model.
module tb_q2_sequencer;

    localparam int SC = 12;

    typedef logic [6:0] obs_t;  // {s1, s0, s2, s3, ws, halted, dep_ws}
    localparam obs_t HALT_OBS = 7'b0000010;
    localparam obs_t DEP_OBS  = 7'b0000011;

    logic clk = 1'b0;
    logic rst, run_sw, dep_sw, deref, o0, o1, o2, step_sw;
    logic s0, s1, s2, s3, ws, halted, dep_ws;
    int   n_cmp = 0;
    int   n_fail = 0;

    q2_sequencer #(.SHIFT_CYCLES(SC), .CNT_W(4)) dut (
        .clk(clk),
        .rst(rst),
`ifdef Q2_SINGLE_STEP_EN
        .step_sw(step_sw),
`endif
        .run_sw(run_sw),
        .dep_sw(dep_sw),
        .deref(deref),
        .o0(o0),
        .o1(o1),
        .o2(o2),
        .s0(s0),
        .s1(s1),
        .s2(s2),
        .s3(s3),
        .ws(ws),
        .halted(halted),
        .dep_ws(dep_ws)
    );

    always #5 clk = ~clk;

    function automatic obs_t obs();
        return {s1, s0, s2, s3, ws, halted, dep_ws};
    endfunction

    // Runs one instruction from FETCH setup, checking every clock against the phase list.
    task automatic run_instr(input bit dr, input bit o2v, input bit o1v, input bit o0v,
                             input int drop_at, input int abort_at, input bit rnd_dep);
        logic [1:0] ph[$];
        obs_t       e[$];
        ph = {2'b00};
        if (dr) ph.push_back(2'b01);
        if (!o2v) ph.push_back(2'b10);
        ph.push_back(2'b11);
        foreach (ph[k])
            for (int w = 0; w < 2; w++) e.push_back({ph[k], 2'b00, w == 1, 2'b00});
        if ((o0v | o1v) & o2v)
            for (int k = 0; k < SC; k++)
                for (int w = 0; w < 2; w++) e.push_back({2'b11, k < SC - 1, k == SC - 1, w == 1, 2'b00});
        for (int i = 0; i < e.size(); i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs() !== e[i]) begin
                n_fail++;
                $display("FAIL instr(%0b%0b%0b%0b) cycle %0d: got %b want %b", dr, o2v, o1v, o0v, i, obs(), e[i]);
            end
            if (i == 0) begin deref = dr; o2 = o2v; o1 = o1v; o0 = o0v; end
            if (i == drop_at) run_sw = 1'b0;
            if (rnd_dep) dep_sw = 1'($urandom_range(0, 1));
            if (i == abort_at) begin
                rst = 1'b1;
                #1;
                n_cmp++;
                if (obs() !== HALT_OBS) begin
                    n_fail++;
                    $display("FAIL async_reset: got %b want %b", obs(), HALT_OBS);
                end
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; run_sw = 1'b0; dep_sw = 1'b0; step_sw = 1'b0;
        deref = 1'b0; o0 = 1'b0; o1 = 1'b0; o2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs() !== HALT_OBS) begin n_fail++; $display("FAIL reset_state: got %b want %b", obs(), HALT_OBS); end
        rst = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (obs() !== HALT_OBS) begin n_fail++; $display("FAIL idle_halt: got %b want %b", obs(), HALT_OBS); end
    endtask

    task automatic test_basic();
        run_sw = 1'b1;
        run_instr(0, 0, 0, 0, -1, -1, 0);
        run_instr(1, 1, 0, 0, -1, -1, 0);
        run_instr(0, 1, 0, 1, -1, -1, 0);
        run_instr(1, 0, 1, 1, -1, -1, 0);
    endtask

    task automatic test_halt_drop();
        run_instr(0, 1, 1, 0, 8, -1, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (obs() !== HALT_OBS) begin n_fail++; $display("FAIL halt_after_alu %0d: got %b want %b", i, obs(), HALT_OBS); end
        end
    endtask

    task automatic test_deposit();
        obs_t ex;
        dep_sw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            ex = (i == 0) ? DEP_OBS : HALT_OBS;
            n_cmp++;
            if (obs() !== ex) begin n_fail++; $display("FAIL deposit_hold %0d: got %b want %b", i, obs(), ex); end
        end
        dep_sw = 1'b0;
        @(posedge clk); #1;
        dep_sw = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            dep_sw = 1'b0;
            ex = (i == 0) ? DEP_OBS : HALT_OBS;
            n_cmp++;
            if (obs() !== ex) begin n_fail++; $display("FAIL deposit_pulse %0d: got %b want %b", i, obs(), ex); end
        end
    endtask

    task automatic test_run_vs_dep();
        run_sw = 1'b1;
        dep_sw = 1'b1;
        run_instr(1, 0, 0, 0, -1, -1, 1);
        run_instr(0, 1, 1, 1, -1, -1, 1);
    endtask

    task automatic test_random();
        bit dr, a, b, c;
        int drop;
        for (int n = 0; n < 30; n++) begin
            run_sw = 1'b1;
            dr = 1'($urandom_range(0, 1)); a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr(dr, a, b, c, drop, -1, 1);
            if (drop >= 0) begin
                dep_sw = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    @(posedge clk); #1;
                    n_cmp++;
                    if (obs() !== HALT_OBS) begin n_fail++; $display("FAIL random_halt %0d/%0d: got %b want %b", n, i, obs(), HALT_OBS); end
                end
            end
        end
    endtask

    task automatic test_reset_mid_alu();
        run_sw = 1'b1;
        dep_sw = 1'b0;
        run_instr(0, 1, 0, 1, -1, 17, 0);
        @(posedge clk); #1;
        n_cmp++;
        if (obs() !== HALT_OBS) begin n_fail++; $display("FAIL reset_held: got %b want %b", obs(), HALT_OBS); end
        rst = 1'b0;
        run_instr(0, 0, 1, 0, -1, -1, 0);
        run_instr(0, 1, 0, 0, -1, -1, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_halt_drop();
        test_deposit();
        test_run_vs_dep();
        test_random();
        test_reset_mid_alu();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
